// File: rtl/coreir_mem_pkg.sv
// Shared constants and helpers for the synchronous-read memory family.
package coreir_mem_pkg;

  // Same-address read-during-write policy.
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Supported registered-read depth, in rising edges from request to data.
  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 3;

  // Address width.  A single-word memory still carries a 1-bit address.
  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit latency_legal(input int lat);
    return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
  endfunction

  function automatic bit rdw_mode_legal(input int mode);
    return (mode == RDW_READ_FIRST) || (mode == RDW_WRITE_FIRST);
  endfunction

endpackage

// File: rtl/coreir_mem_rdpipe.sv
// Read-response delay line carrying {valid, data}.  Every stage holds its
// data when no valid token passes through it, so the last stage keeps the
// most recently delivered word across bubbles.  Async clear drops all tokens.
module coreir_mem_rdpipe #(
  parameter int width  = 1,
  parameter int stages = 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  output logic [width-1:0] out_data
);

  logic [stages-1:0] valid_q;
  logic [stages-1:0] valid_d;
  logic [width-1:0]  data_q [stages];
  logic [width-1:0]  data_d [stages];

  // Shift tokens one stage per edge; a stage's data only moves with a valid token.
  always_comb begin
    valid_d = '0;
    data_d  = data_q;
    valid_d[0] = in_valid;
    if (in_valid) begin
      data_d[0] = in_data;
    end
    for (int i = 1; i < stages; i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) begin
        data_d[i] = data_q[i-1];
      end
    end
  end

  // Stage registers, cleared asynchronously.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q <= '0;
      for (int i = 0; i < stages; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[stages-1];
  assign out_data  = data_q[stages-1];

endmodule

// File: rtl/coreir_sync_mem.sv
// Single-write-port memory with a registered, pipelined read port.
// Array contents survive arst; only the read pipeline is cleared.
module coreir_sync_mem
  import coreir_mem_pkg::*;
#(
  parameter int                     width        = 1,
  parameter int                     depth        = 1,
  parameter bit                     has_init     = 1'b0,
  parameter logic [width*depth-1:0] init         = '0,
  parameter int                     read_latency = 1,
  parameter int                     rdw_mode     = RDW_READ_FIRST,
  localparam int                    AW           = calc_aw(depth)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [width-1:0] wdata,
  input  logic [AW-1:0]    waddr,
  input  logic             wen,
  input  logic [AW-1:0]    raddr,
  input  logic             ren,
  output logic [width-1:0] rdata,
  output logic             rvalid
);

  // Reject unsupported configurations at elaboration.
  if (!latency_legal(read_latency)) begin : g_bad_latency
    $error("coreir_sync_mem: read_latency %0d outside %0d..%0d",
           read_latency, READ_LATENCY_MIN, READ_LATENCY_MAX);
  end
  if (!rdw_mode_legal(rdw_mode)) begin : g_bad_rdw_mode
    $error("coreir_sync_mem: rdw_mode %0d is not READ_FIRST or WRITE_FIRST", rdw_mode);
  end

  // One extra bit so depth itself is representable for the range compare.
  localparam logic [AW:0] DEPTH_L = (AW+1)'(depth);

  typedef logic [width-1:0] word_t;
  typedef word_t            mem_t [depth];

  // Power-up image: the init vector when requested, otherwise unknown.
  function automatic mem_t init_mem();
    mem_t m;
    for (int j = 0; j < depth; j++) begin
      m[j] = has_init ? init[j*width +: width] : 'x;
    end
    return m;
  endfunction

  mem_t mem_q = init_mem();

  logic  wr_in_range;
  logic  rd_in_range;
  logic  wr_fire;
  logic  rd_valid_d;
  word_t rd_data_d;

  // Address qualification, write strobe and the read-side word selection.
  always_comb begin
    wr_in_range = ({1'b0, waddr} < DEPTH_L);
    rd_in_range = ({1'b0, raddr} < DEPTH_L);
    wr_fire     = wen && !arst && wr_in_range;
    rd_valid_d  = ren && !arst;
    rd_data_d   = '0;
    if (rd_in_range) begin
      // The array still holds pre-write data this cycle, which is READ_FIRST
      // for free; WRITE_FIRST bypasses the incoming word instead.
      rd_data_d = mem_q[raddr];
      if ((rdw_mode == RDW_WRITE_FIRST) && wr_fire && (waddr == raddr)) begin
        rd_data_d = wdata;
      end
    end
  end

  // Array write port; deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[waddr] <= wdata;
    end
  end

  coreir_mem_rdpipe #(
    .width  (width),
    .stages (read_latency)
  ) u_rdpipe (
    .clk       (clk),
    .arst      (arst),
    .in_valid  (rd_valid_d),
    .in_data   (rd_data_d),
    .out_valid (rvalid),
    .out_data  (rdata)
  );

endmodule

// File: doc/coreir_sync_mem.md
# coreir_sync_mem

Synchronous-read, parametrised successor to the asynchronous-read memory primitive. It provides one write port and one registered read port with a configurable read latency of 1–3 cycles and a `rvalid` strobe. Read-during-write behaviour at the same address is selectable, and contents can optionally be initialised at time zero. It sits under the generated Memory/ROM wrappers wherever a registered, timing-friendly read path is required.

## Interface
Parameters:
- `width`, 1: data width in bits, ≥1.
- `depth`, 1: number of words, ≥1; need not be a power of two.
- `has_init`, 1'b0: when 1, load `init` into the array at time zero.
- `init`, 0: `width*depth` bits; word j occupies bits `[(j+1)*width-1 : j*width]`.
- `read_latency`, 1: rising edges from read request to data, 1..3.
- `rdw_mode`, 0: same-address read-during-write. 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data).

Derived: `AW = (depth>1) ? $clog2(depth) : 1`.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `arst` input 1: asynchronous, active-high reset of the read pipeline only.
- `wdata` input width: write data.
- `waddr` input AW: write address.
- `wen` input 1: write enable.
- `raddr` input AW: read address.
- `ren` input 1: read request.
- `rdata` output width: read data; holds its value between reads.
- `rvalid` output 1: `rdata` carries the response to a read request this cycle.

## Operation
- Write: when `wen`=1 and `waddr`<`depth`, `data[waddr]` takes `wdata` at the edge. When `waddr`≥`depth`, the write is silently dropped.
- Read: `ren` and `raddr` are sampled at edge N. The word enters a pipeline `read_latency` stages deep.
- Out-of-range read (`raddr`≥`depth`): the response is `rdata`=0 with `rvalid`=1.
- Reads are fully pipelined: one request per cycle, no stalls, no backpressure.
- Read-during-write, same address, same edge:
  - READ_FIRST returns the pre-write contents.
  - WRITE_FIRST returns `wdata`.
  - Different addresses never interact.
- `ren`=0 at an edge inserts a bubble: that slot has `rvalid`=0, and `rdata` keeps its last delivered value (no update).
- Reset:
  - `arst`=1 immediately forces `rdata`=0, `rvalid`=0 and clears all pipeline valid/data stages.
  - In-flight reads are discarded and produce no `rvalid`.
  - Array contents are not affected by `arst`.
  - Writes and read sampling are suppressed while `arst`=1.
  - The first edge with `arst`=0 samples normally.
- Init: with `has_init`=1, word j = `init` slice j at time zero. Otherwise contents are X until written.

## Timing
- Read latency: a request sampled at edge N appears on `rdata`/`rvalid` after edge N+`read_latency`-1. With latency 1, data is visible in the cycle following edge N.
- Write-to-read visibility:
  - A write at edge N is visible to any read sampled at edge N+1.
  - A same-edge read follows `rdw_mode`.
- `rvalid` is a single-cycle strobe per request. Back-to-back requests give a continuous `rvalid`.
- Reset outputs: `rdata`=0, `rvalid`=0.
- Reset assertion is asynchronous; deassertion is assumed synchronised externally.

## Structure
- Package `coreir_mem_pkg` holds:
  - constants `RDW_READ_FIRST`=0 and `RDW_WRITE_FIRST`=1;
  - the `AW` computation function;
  - the legal `read_latency` range (1..3), checked by an elaboration-time assertion.
- Sub-module `coreir_mem_rdpipe` (parameters `width`, `stages`): a delay line for {valid, data} with async clear. Its output data register loads only when the valid bit is set.
- Top level holds the array, the write logic, the read-during-write mux and the out-of-range masking.

## Test plan
- Init readback: `width`=5, `depth`=4, `init`={11,21,0,5}, latency 1. `ren` with `raddr`=0,1,2,3 on consecutive edges → `rdata`=5,0,21,11, with `rvalid`=1 for 4 consecutive cycles.
- Latency 3 with a bubble: requests to addresses 2, (none), 3 → `rvalid` pattern 1,0,1 starting 3 edges after the first request. `rdata`=21, held at 21, then 11.
- Read-during-write: `data[1]`=0, then `wen`=1, `waddr`=1, `wdata`=7 with `ren`=1, `raddr`=1 on the same edge:
  - `rdw_mode`=0 → 0;
  - `rdw_mode`=1 → 7;
  - a read at the next edge returns 7 in both modes.
- Out-of-range, `depth`=3:
  - a write to address 3 is dropped, and addresses 0..2 are unchanged;
  - a read of address 3 → `rdata`=0, `rvalid`=1.
- Reset mid-operation, latency 2: assert `arst` one cycle after a read of address 2 → `rdata`=0 and `rvalid`=0 immediately, with no `rvalid` for that read. After release, a read of address 2 still returns 21 (array preserved).
- Throughput: 16 back-to-back writes then 16 back-to-back reads, `depth`=16, `width`=8, latency 2 → 16 consecutive `rvalid` cycles with matching data.
